main_fsm: RTL and testbench
===========================

Name: main_fsm

Overview:
- Multicycle MIPS main controller: a Moore FSM, with memory-wait gating, that sequences fetch/decode/execute/memory/writeback.
- Drives the datapath enables and mux selects.
- Produces the 2-bit aluop consumed by the ALU decoder (00 = add, 01 = subtract/compare, 10 = use funct). It is the producer end of that interface.
- Sits in the controller next to the ALU decoder; its inputs come from the instruction register opcode field and the memory ready signal.

Parameters:
- MEM_WAIT_EN, 1, when 0 memready is ignored and treated as constant 1 (zero-wait memory).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state FETCH
- op  input  6  opcode from instruction register, bits [31:26]
- memready  input  1  memory completes the current access this cycle
- pcwrite  output  1  unconditional PC write enable
- branch  output  1  conditional PC write (datapath ANDs with zero)
- irwrite  output  1  instruction register write enable
- memwrite  output  1  data memory write strobe
- regwrite  output  1  register file write enable
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  output  1  writeback select: 1 = memory data, 0 = ALUOut
- regdst  output  1  destination register: 1 = rd, 0 = rt
- alusrca  output  1  ALU A: 0 = PC, 1 = register A
- alusrcb  output  2  ALU B: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2
- pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- aluop  output  2  to ALU decoder
- illegal_op  output  1  unrecognised opcode seen in DECODE
- state  output  4  current state (debug/verification)

Behaviour:
- State register: 4 bits; the only sequential element. On async reset it goes to FETCH=0.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 go to FETCH next cycle with all outputs 0.
- Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- Transitions:
  - FETCH -> DECODE when memready, else stay in FETCH.
  - DECODE -> MEMADR (LW/SW), EXECUTE (RTYPE), BRANCH (BEQ), ADDIEX (ADDI), JUMP (J). Any other opcode -> FETCH.
  - MEMADR -> MEMRD (LW) or MEMWR (SW).
  - MEMRD -> MEMWB when memready, else stay.
  - MEMWR -> FETCH when memready, else stay.
  - EXECUTE -> ALUWB -> FETCH.
  - ADDIEX -> ADDIWB -> FETCH.
  - BRANCH -> FETCH; JUMP -> FETCH.
- Output rule: every output not listed for a state is 0.
- Output values per state:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=memready, pcwrite=memready. These two enables are gated so PC/IR update exactly once, on the completing cycle.
  - DECODE: alusrcb=11, aluop=00; illegal_op=1 if opcode unrecognised.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1, regdst=0.
  - MEMWR: iord=1, memwrite=1. memwrite is held for the whole wait.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Reset values: while reset is high, pcwrite, irwrite, branch, memwrite, regwrite and illegal_op are forced 0. Remaining outputs take FETCH values (alusrcb=01, others 0); state=0.
- Reset mid-operation: state returns to FETCH immediately (asynchronously). No partial writeback enable may be asserted after reset rises.
- Latency in cycles with memready always 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3. Each memory wait cycle adds 1.
- op is sampled only in DECODE and MEMADR; changes on op in other states have no effect.
- All outputs are combinational from state (plus memready in FETCH). No output registers.

Decomposition:
- Package mips_ctl_pkg:
  - state enum (4-bit)
  - opcode localparams
  - aluop codes: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, shared with the ALU decoder
  - alusrcb and pcsrc select constants
- One natural sub-module: main_fsm_outdec, a pure combinational state -> control-word decoder. main_fsm holds the state register, next-state logic and memready gating.

Test Plan:
- Reset, then op=100011 (LW), memready=1:
  - states go 0,1,2,3,4,0.
  - aluop is 00 in FETCH, DECODE and MEMADR.
  - regwrite=1 and memtoreg=1 only in state 4.
- op=000000 (R-type):
  - EXECUTE shows aluop=10, alusrca=1, alusrcb=00.
  - ALUWB shows regdst=1, regwrite=1.
  - Returns to FETCH after 4 cycles.
- op=000100 (BEQ): BRANCH shows aluop=01, pcsrc=01, branch=1, pcwrite=0; 3 cycles total.
- memready held 0 for 3 cycles in FETCH, then 1:
  - stays in state 0 with irwrite=pcwrite=0 for 3 cycles.
  - single-cycle irwrite=pcwrite=1, then DECODE.
- SW with memready low 2 cycles in MEMWR: memwrite=1 for 3 consecutive cycles, then FETCH.
- op=111111:
  - DECODE asserts illegal_op=1 for one cycle, then FETCH.
  - Separately, reset asserted mid-ADDIWB forces state=0 and regwrite=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/mips_ctl_pkg.sv
// mips_ctl_pkg: shared state encoding, opcodes and control-field codes for the
// multicycle MIPS controller (main FSM and ALU decoder).
package mips_ctl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
    endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// main_fsm_outdec: pure combinational state -> control-word decoder.
module main_fsm_outdec
    import mips_ctl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       pcwrite,
    output logic       branch,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op
);
    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state)
            FETCH: begin
                alusrcb = SRCB_FOUR;
                irwrite = memready;
                pcwrite = memready;
            end
            DECODE: begin
                alusrcb    = SRCB_IMMSH;
                illegal_op = !is_legal(op);
            end
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/main_fsm.sv
// main_fsm: multicycle MIPS main controller; state register, next-state logic
// and memory-wait gating, with control outputs decoded from the current state.
module main_fsm
    import mips_ctl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       pcwrite,
    output logic       branch,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic [3:0] state
);
    state_t cur, nxt;
    logic   ready;

    assign ready = MEM_WAIT_EN ? memready : 1'b1;
    assign state = cur;

    always_ff @(posedge clk or posedge reset)
        if (reset) cur <= FETCH;
        else       cur <= nxt;

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = ready ? DECODE : FETCH;
            DECODE:  nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
                           (op == OP_RTYPE) ? EXECUTE :
                           (op == OP_BEQ)   ? BRANCH  :
                           (op == OP_ADDI)  ? ADDIEX  :
                           (op == OP_J)     ? JUMP    : FETCH;
            MEMADR:  nxt = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   nxt = ready ? MEMWB : MEMRD;
            MEMWR:   nxt = ready ? FETCH : MEMWR;
            EXECUTE: nxt = ALUWB;
            ADDIEX:  nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end

    // Gating ready with reset keeps the FETCH write enables low while reset is held.
    main_fsm_outdec u_outdec (
        .state      (cur),
        .op         (op),
        .memready   (ready & ~reset),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .aluop      (aluop),
        .illegal_op (illegal_op)
    );
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: randomized scoreboard bench; expected per-cycle state/control
// words come from an instruction-level model of the controller.
module tb_main_fsm;
    logic clk = 1'b0, reset = 1'b1, memready = 1'b1;
    logic [5:0] op = 6'd0;
    logic pcwrite, branch, irwrite, memwrite, regwrite, iord, memtoreg, regdst;
    logic alusrca, illegal_op;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;
    int checks = 0, failures = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    main_fsm #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .memready(memready),
        .pcwrite(pcwrite), .branch(branch), .irwrite(irwrite), .memwrite(memwrite),
        .regwrite(regwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .illegal_op(illegal_op), .state(state)
    );

    wire [15:0] act_cw = {pcwrite, branch, irwrite, memwrite, regwrite, iord, memtoreg,
                          regdst, alusrca, alusrcb, pcsrc, aluop, illegal_op};

    // Control word expected in a given phase of an instruction.
    function automatic logic [15:0] cw(input int s, input logic r, input logic [5:0] o);
        logic pw = 0, br = 0, ir = 0, mw = 0, rw = 0, io = 0, mr = 0, rd = 0, sa = 0, il = 0;
        logic [1:0] sb = 0, ps = 0, ao = 0;
        case (s)
            0: begin sb = 2'b01; pw = r; ir = r; end
            1: begin sb = 2'b11; il = !(o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010}); end
            2, 9: begin sa = 1; sb = 2'b10; end
            3: io = 1;
            4: begin mr = 1; rw = 1; end
            5: begin io = 1; mw = 1; end
            6: begin sa = 1; ao = 2'b10; end
            7: begin rd = 1; rw = 1; end
            8: begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
            10: rw = 1;
            11: begin ps = 2'b10; pw = 1; end
            default: ;
        endcase
        return {pw, br, ir, mw, rw, io, mr, rd, sa, sb, ps, ao, il};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step(input int s, input logic r, input logic [5:0] o);
        memready = r;
        op = o;
        exp_q.push_back({s[3:0], cw(s, r, o)});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    // Instruction-level model: phase list for each opcode, memory waits inserted.
    task automatic run_instr(input logic [5:0] iop, input int fw, input int mw);
        int ph[$];
        for (int i = 0; i < fw; i++) step(0, 1'b0, rnd_op());
        step(0, 1'b1, rnd_op());
        step(1, 1'($urandom), iop);
        case (iop)
            6'b100011: ph = '{2, 3, 4};
            6'b101011: ph = '{2, 5};
            6'b000000: ph = '{6, 7};
            6'b001000: ph = '{9, 10};
            6'b000100: ph = '{8};
            6'b000010: ph = '{11};
            default:   ph = '{};
        endcase
        foreach (ph[k]) begin
            if (ph[k] == 3 || ph[k] == 5) begin
                for (int i = 0; i < mw; i++) step(ph[k], 1'b0, rnd_op());
                step(ph[k], 1'b1, rnd_op());
            end else begin
                step(ph[k], 1'($urandom), ph[k] == 2 ? iop : rnd_op());
            end
        end
    endtask

    always @(negedge clk)
        if (!reset && exp_q.size() > 0) begin
            logic [19:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({state, act_cw} !== e) begin
                failures++;
                $display("FAIL seq got state=%0d cw=%b want state=%0d cw=%b",
                         state, act_cw, e[19:16], e[15:0]);
            end
        end

    initial begin
        logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        int t;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state_cw", {state, act_cw}, {4'd0, cw(0, 1'b0, 6'd0)});
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(6'b100011, 0, 0);
        run_instr(6'b000000, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 3, 0);
        run_instr(6'b101011, 0, 2);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b100011, 1, 2);
        for (int n = 0; n < 60; n++)
            run_instr(($urandom_range(0, 4) == 0) ? rnd_op() : ops[$urandom_range(0, 5)],
                      $urandom_range(0, 2), $urandom_range(0, 2));
        step(0, 1'b1, rnd_op());
        step(1, 1'b0, 6'b001000);
        step(9, 1'b1, rnd_op());
        memready = 1'b1;
        check("addiwb_state", {28'd0, state}, 32'd10);
        check("addiwb_regwrite", {31'd0, regwrite}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_state", {28'd0, state}, 32'd0);
        check("async_reset_wen", {29'd0, regwrite, pcwrite, irwrite}, 32'd0);
        t = 0;
        while (exp_q.size() > 0 && t < 10) begin
            @(posedge clk);
            t++;
        end
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
